// File: rtl/mem8x8_ctrl.sv
// 8-word x 8-bit register memory behind a valid/rw request port, returning read data on a shared tri-state bus.
// Optional MEM_CLEAR_ON_RESET_EN: synchronous reset also zeroes every memory word.
module mem8x8_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRIVE = 2'd3
    } state_t;

    state_t            state;
    logic              drive;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Gating with rst_n releases the bus in the reset cycle itself, not one edge later.
    assign data = (drive && rst_n) ? out_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            drive  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            out_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drive <= 1'b0;
                    done  <= 1'b0;
                    if (valid) begin
                        addr_q <= addr;
                        busy   <= 1'b1;
                        if (rw) begin
                            data_q <= data;
                            done   <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            state  <= READ;
                        end
                    end
                end
                WRITE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                READ: begin
                    out_q <= mem[addr_q];
                    drive <= 1'b1;
                    done  <= 1'b1;
                    state <= DRIVE;
                end
                DRIVE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    drive <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    drive <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A write still in flight when reset arrives is dropped.
    always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_ON_RESET_EN
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == WRITE) begin
            mem[addr_q] <= data_q;
        end
`else
        if (rst_n && state == WRITE) begin
            mem[addr_q] <= data_q;
        end
`endif
    end

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Directed self-checking bench for mem8x8_ctrl; the bus is probed for high-Z by weakly
// sampling it while the bench drives 0 (a DUT driver would show up as non-zero or X).
module tb_mem8x8_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       rw;
    logic [2:0] addr;
    logic       busy;
    logic       done;
    logic       tb_oe;
    logic [7:0] tb_drv;
    wire  [7:0] data;

    int tests = 0;
    int fails = 0;

    assign data = tb_oe ? tb_drv : 8'hzz;

    mem8x8_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .rw    (rw),
        .addr  (addr),
        .data  (data),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // Drive 0 onto the bus briefly and return what resolves; 0 means the DUT is not driving.
    task automatic probe_bus(output logic [7:0] v);
        tb_drv = 8'h00;
        tb_oe  = 1'b1;
        #1;
        v      = data;
        tb_oe  = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = a; tb_drv = d; tb_oe = 1'b1;
        @(negedge clk);
        valid = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        valid = 1'b1; rw = 1'b0; addr = a;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        v = data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b done=%b, expected 0 0", busy, done);
        end
        probe_bus(v);
        tests++;
        if (v !== 8'h00) begin
            fails++;
            $display("FAIL reset_bus_z: bus=%h, expected released", v);
        end
        rst_n = 1'b1;
`ifdef MEM_CLEAR_ON_RESET_EN
        do_read(3'd5, v);
        tests++;
        if (v !== 8'h00) begin
            fails++;
            $display("FAIL reset_mem_clear: mem[5]=%h, expected 00", v);
        end
`endif
    endtask

    task automatic test_write();
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 3'd3; tb_drv = 8'hA5; tb_oe = 1'b1;
        @(negedge clk);
        valid = 1'b0; tb_oe = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL write_cycle: busy=%b done=%b, expected 1 1", busy, done);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL write_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_read();
        logic [7:0] v;
        @(negedge clk);
        valid = 1'b1; rw = 1'b0; addr = 3'd3;
        @(negedge clk);
        valid = 1'b0;
        probe_bus(v);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || v !== 8'h00) begin
            fails++;
            $display("FAIL read_cycle: busy=%b done=%b bus=%h, expected 1 0 released", busy, done, v);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || done !== 1'b1 || data !== 8'hA5) begin
            fails++;
            $display("FAIL drive_cycle: busy=%b done=%b data=%h, expected 1 1 a5", busy, done, data);
        end
        @(negedge clk);
        probe_bus(v);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || v !== 8'h00) begin
            fails++;
            $display("FAIL read_after: busy=%b done=%b bus=%h, expected 0 0 released", busy, done, v);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] v;
        do_write(3'd0, 8'h0F);
        do_write(3'd7, 8'hF0);
        do_read(3'd0, v);
        tests++;
        if (v !== 8'h0F) begin
            fails++;
            $display("FAIL bound_addr0: got %h, expected 0f", v);
        end
        do_read(3'd7, v);
        tests++;
        if (v !== 8'hF0) begin
            fails++;
            $display("FAIL bound_addr7: got %h, expected f0", v);
        end
        do_read(3'd3, v);
        tests++;
        if (v !== 8'hA5) begin
            fails++;
            $display("FAIL bound_alias3: got %h, expected a5", v);
        end
    endtask

    task automatic test_held_request();
        logic [2:0] a_tab [6] = '{3'd1, 3'd4, 3'd5, 3'd1, 3'd6, 3'd5};
        logic [7:0] d_tab [6] = '{8'h11, 8'h44, 8'h55, 8'hEE, 8'h66, 8'hFF};
        logic [7:0] v;
        int dcnt = 0;
        do_write(3'd4, 8'h99);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0 && done === 1'b1) dcnt++;
            valid = 1'b1; rw = 1'b1; addr = a_tab[i]; tb_drv = d_tab[i]; tb_oe = 1'b1;
        end
        @(negedge clk);
        if (done === 1'b1) dcnt++;
        valid = 1'b0; tb_oe = 1'b0;
        tests++;
        if (dcnt != 3) begin
            fails++;
            $display("FAIL held_done_count: got %0d, expected 3", dcnt);
        end
        do_read(3'd1, v);
        tests++;
        if (v !== 8'h11) begin
            fails++;
            $display("FAIL held_addr1: got %h, expected 11", v);
        end
        do_read(3'd4, v);
        tests++;
        if (v !== 8'h99) begin
            fails++;
            $display("FAIL held_addr4: got %h, expected 99", v);
        end
        do_read(3'd5, v);
        tests++;
        if (v !== 8'h55) begin
            fails++;
            $display("FAIL held_addr5: got %h, expected 55", v);
        end
        do_read(3'd6, v);
        tests++;
        if (v !== 8'h66) begin
            fails++;
            $display("FAIL held_addr6: got %h, expected 66", v);
        end
    endtask

    task automatic test_back_to_back();
        int dcnt = 0;
        int dbad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0 && done === 1'b1) begin
                dcnt++;
                if (data !== 8'hA5) dbad++;
            end
            valid = 1'b1; rw = 1'b0; addr = 3'd3;
        end
        @(negedge clk);
        if (done === 1'b1) dcnt++;
        valid = 1'b0;
        tests++;
        if (dcnt != 2 || dbad != 0) begin
            fails++;
            $display("FAIL b2b_reads: dones=%0d bad=%0d, expected 2 0", dcnt, dbad);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] v;
        do_write(3'd2, 8'h77);
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 3'd2; tb_drv = 8'h3C; tb_oe = 1'b1;
        @(negedge clk);
        valid = 1'b0; tb_oe = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_write_flags: busy=%b done=%b, expected 0 0", busy, done);
        end
        rst_n = 1'b1;
        do_read(3'd2, v);
        tests++;
        if (v !== 8'h77) begin
            fails++;
            $display("FAIL rst_mid_write_mem: mem[2]=%h, expected 77", v);
        end
        // Abort a read in its DRIVE cycle; the bus must release before the next edge.
        @(negedge clk);
        valid = 1'b1; rw = 1'b0; addr = 3'd3;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        probe_bus(v);
        tests++;
        if (v !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_drive_bus: bus=%h, expected released", v);
        end
        @(negedge clk);
        probe_bus(v);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || v !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_drive_state: busy=%b done=%b bus=%h, expected 0 0 released", busy, done, v);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        rw     = 1'b0;
        addr   = '0;
        tb_oe  = 1'b0;
        tb_drv = '0;
        test_reset();
        test_write();
        test_read();
        test_boundaries();
        test_held_request();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
